// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   state_t    : per-channel request FSM state (IDLE / WAIT / RESP)
//   lat_cnt_w  : width of the latency down-counter for a given LATENCY
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter is loaded with LATENCY-1; sized for LATENCY+1 so small
  // values of LATENCY still get at least one bit.
  function automatic int lat_cnt_w(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_resp_channel.sv
// One request channel of the memory responder (used for both read and write).
// Latches the request payload on accept, waits LATENCY cycles, then holds
// ready until the requester drops valid.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   valid       : request valid from the requester
//   payload_in  : request payload (address, or {address, data} for writes)
//   ready       : response valid / write acknowledge (high in RESP)
//   fire        : high in the cycle whose closing edge enters RESP; the
//                 parent captures read data or commits the write on that edge
//   payload     : payload belonging to the request (live input while IDLE so
//                 LATENCY=1 can fire on the accept edge, latched otherwise)
module mem_resp_channel
  import mem_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 ready,
  output logic                 fire,
  output logic [PAYLOAD_W-1:0] payload
);

  localparam int CW = lat_cnt_w(LATENCY);

  state_t             state, state_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [PAYLOAD_W-1:0] payload_q;
  logic               accept;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Payload is data, not control: no reset needed
  always_ff @(posedge clk) begin
    if (accept) payload_q <= payload_in;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (valid) begin
          if (LATENCY <= 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            count_nxt = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // Valid dropping here is an abort: nothing is captured or committed
        if (!valid)            state_nxt = IDLE;
        else if (count == '0)  state_nxt = RESP;
        else                   count_nxt = count - CW'(1);
      end
      RESP: begin
        if (!valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    accept  = (state == IDLE) && valid;
    ready   = (state == RESP);
    // Gated by reset so an edge seen while reset is held never commits
    fire    = (state != RESP) && (state_nxt == RESP) && !reset;
    payload = (state == IDLE) ? payload_in : payload_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the GPU external memory valid/ready protocol.
// NUM_CHANNELS read channels return DATA_READ_NUM consecutive words (address
// wraps) after LATENCY cycles; NUM_CHANNELS write channels commit after the
// same latency when WRITE_ENABLE=1. A host port preloads and peeks storage.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   mem_read_*        : per-channel read valid/address in, ready/data out
//   mem_write_*       : per-channel write valid/address/data in, ready out
//   host_write_en     : preload strobe (host_addr <= host_wdata)
//   host_addr         : preload / peek address
//   host_wdata        : preload data
//   host_rdata        : combinational peek of the word at host_addr
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CHANNELS  = 2,
  parameter int WRITE_ENABLE  = 1,
  parameter int DATA_READ_NUM = 1,
  parameter int LATENCY       = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CHANNELS-1:0]            mem_read_valid,
  input  logic [ADDR_BITS-1:0]               mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]            mem_read_ready,
  output logic [DATA_READ_NUM*DATA_BITS-1:0] mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]            mem_write_valid,
  input  logic [ADDR_BITS-1:0]               mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]               mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0]            mem_write_ready,
  input  logic                               host_write_en,
  input  logic [ADDR_BITS-1:0]               host_addr,
  input  logic [DATA_BITS-1:0]               host_wdata,
  output logic [DATA_BITS-1:0]               host_rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int WPW   = ADDR_BITS + DATA_BITS;

  logic [DATA_BITS-1:0]    mem      [DEPTH];
  logic [NUM_CHANNELS-1:0] rd_fire, wr_fire, wr_valid;
  logic [ADDR_BITS-1:0]    rd_addr  [NUM_CHANNELS];
  logic [WPW-1:0]          wr_req_in[NUM_CHANNELS];
  logic [WPW-1:0]          wr_req   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    cap_word [NUM_CHANNELS][DATA_READ_NUM];

  // With writes disabled the channels never see a request, so ready stays 0
  assign wr_valid = (WRITE_ENABLE != 0) ? mem_write_valid : '0;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    mem_resp_channel #(.LATENCY(LATENCY), .PAYLOAD_W(ADDR_BITS)) u_rd (
      .clk        (clk),
      .reset      (reset),
      .valid      (mem_read_valid[ch]),
      .payload_in (mem_read_address[ch]),
      .ready      (mem_read_ready[ch]),
      .fire       (rd_fire[ch]),
      .payload    (rd_addr[ch])
    );

    assign wr_req_in[ch] = {mem_write_address[ch], mem_write_data[ch]};

    mem_resp_channel #(.LATENCY(LATENCY), .PAYLOAD_W(WPW)) u_wr (
      .clk        (clk),
      .reset      (reset),
      .valid      (wr_valid[ch]),
      .payload_in (wr_req_in[ch]),
      .ready      (mem_write_ready[ch]),
      .fire       (wr_fire[ch]),
      .payload    (wr_req[ch])
    );

    // Consecutive words; the address sum is truncated so it wraps
    for (genvar k = 0; k < DATA_READ_NUM; k++) begin : g_word
      logic [ADDR_BITS-1:0] word_addr;
      assign word_addr         = rd_addr[ch] + ADDR_BITS'(k);
      assign cap_word[ch][k]   = mem[word_addr];
    end
  end

  // Storage: host first, then channels from highest to lowest index, so the
  // last non-blocking write (lowest channel) wins on a collision.
  always_ff @(posedge clk) begin
    if (host_write_en) mem[host_addr] <= host_wdata;
    for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
      if (wr_fire[ch]) mem[wr_req[ch][WPW-1 -: ADDR_BITS]] <= wr_req[ch][DATA_BITS-1:0];
    end
  end

  // Read capture samples storage before this edge's writes land (old value)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) mem_read_data[ch] <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (rd_fire[ch]) begin
          for (int k = 0; k < DATA_READ_NUM; k++)
            mem_read_data[ch][k*DATA_BITS +: DATA_BITS] <= cap_word[ch][k];
        end
      end
    end
  end

  assign host_rdata = mem[host_addr];

endmodule
